// File: rtl/bias_add_unit_if.sv
// Bus bundle for bias_add_unit.
// The master side is the scheduler, bias buffer and PE array. The slave side is the bias/requantise unit.
interface bias_add_unit_if #(
    parameter int LANES  = 4,
    parameter int PSUM_W = 32,
    parameter int BIAS_W = 16,
    parameter int OUT_W  = 8
);
    logic                      calculate_enble;
    logic [4:0]                shift;
    logic                      relu_en;
    logic                      b_rd_en;
    logic                      b_part_end;
    logic [LANES*BIAS_W-1:0]   b_data;
    logic                      pe_out_en;
    logic [LANES*PSUM_W-1:0]   pe_data;
    logic                      o_valid;
    logic [LANES*OUT_W-1:0]    o_data;
    logic                      o_done;
    logic [15:0]               o_cnt;
    logic                      o_err;

    modport master (
        output calculate_enble, shift, relu_en,
        output b_rd_en, b_part_end, b_data,
        output pe_out_en, pe_data,
        input  o_valid, o_data, o_done, o_cnt, o_err
    );

    modport slave (
        input  calculate_enble, shift, relu_en,
        input  b_rd_en, b_part_end, b_data,
        input  pe_out_en, pe_data,
        output o_valid, o_data, o_done, o_cnt, o_err
    );
endinterface

// File: rtl/bias_add_unit.sv
// Bias add / requantise unit.
// Bias vectors and PE partial-sum vectors arrive on independent strobes. Each stream goes into its own
// small alignment FIFO. Whenever both FIFOs hold an entry, the heads are popped together. The unit then
// adds the bias to the partial sum, rounds and shifts the result, saturates it, optionally applies ReLU,
// and registers the result.
module bias_add_unit #(
    parameter int LANES  = 4,
    parameter int PSUM_W = 32,
    parameter int BIAS_W = 16,
    parameter int OUT_W  = 8,
    parameter int DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    bias_add_unit_if.slave   bus
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BENT_W = LANES*BIAS_W + 1;   // {bias vector, part_end tag}
    localparam int PENT_W = LANES*PSUM_W;
    // One guard bit beyond PSUM_W+1 keeps the rounding increment from wrapping.
    localparam int SUM_W  = PSUM_W + 2;

    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (OUT_W-1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // ------------------------------------------------------------------
    // Rounding and saturation helpers
    // ------------------------------------------------------------------
    function automatic logic signed [SUM_W-1:0] round_shift(
        input logic signed [SUM_W-1:0] v,
        input logic        [4:0]       sh
    );
        logic signed [SUM_W-1:0] half;
        if (sh == 5'd0) begin
            return v;
        end
        half = SUM_W'(1) << (sh - 5'd1);
        return (v + half) >>> sh;
    endfunction

    function automatic logic [OUT_W-1:0] sat_relu(
        input logic signed [SUM_W-1:0] v,
        input logic                    relu
    );
        logic signed [OUT_W-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[OUT_W-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[OUT_W-1:0];
        end else begin
            r = v[OUT_W-1:0];
        end
        if (relu && r[OUT_W-1]) begin
            r = '0;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t                      state_q, state_d;
    logic                        run_en;
    logic                        start;

    logic                        brd_q;
    logic                        bend_q;

    logic [BENT_W-1:0]           bmem_q [DEPTH];
    logic [PTR_W-1:0]            bwp_q, brp_q;
    logic [CNT_W-1:0]            bcnt_q;
    logic [PENT_W-1:0]           pmem_q [DEPTH];
    logic [PTR_W-1:0]            pwp_q, prp_q;
    logic [CNT_W-1:0]            pcnt_q;

    logic                        pop;
    logic                        pop_tag;
    logic [BENT_W-1:0]           b_head;
    logic [PENT_W-1:0]           p_head;
    logic                        b_wr, p_wr;
    logic                        b_drop, p_drop;

    logic [4:0]                  shift_q;
    logic                        relu_q;

    logic signed [PSUM_W-1:0]    psum_l;
    logic signed [BIAS_W-1:0]    bias_l;
    logic signed [SUM_W-1:0]     sum_l;
    logic [LANES*OUT_W-1:0]      res_d;

    logic                        valid_q;
    logic                        done_q;
    logic [LANES*OUT_W-1:0]      data_q;
    logic [15:0]                 cnt_q;
    logic                        err_q;

    // ------------------------------------------------------------------
    // FIFO control: pops happen only when both registered counts are non-zero.
    // A start pulse flushes the FIFOs. Any strobe in the same cycle as the start pulse is discarded
    // without raising an error.
    // ------------------------------------------------------------------
    assign start   = bus.calculate_enble;
    assign b_head  = bmem_q[brp_q];
    assign p_head  = pmem_q[prp_q];
    assign pop     = (bcnt_q != '0) && (pcnt_q != '0) && !start;
    assign pop_tag = b_head[0];

    assign b_wr   = brd_q && run_en && !start && ((bcnt_q != CNT_W'(DEPTH)) || pop);
    assign p_wr   = bus.pe_out_en && run_en && !start && ((pcnt_q != CNT_W'(DEPTH)) || pop);
    assign b_drop = brd_q && !start && !b_wr;
    assign p_drop = bus.pe_out_en && !start && !p_wr;

    // Control FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Control FSM: next state. A start pulse re-arms the unit from any state.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_IDLE;
                S_RUN:   if (pop && pop_tag) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Control FSM: outputs. FIFO writes are accepted only while RUN.
    always_comb begin
        run_en = 1'b0;
        case (state_q)
            S_RUN:   run_en = 1'b1;
            default: run_en = 1'b0;
        endcase
    end

    // Delay the bias read strobe by one cycle to line it up with the bias data returned by the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            brd_q  <= 1'b0;
            bend_q <= 1'b0;
        end else begin
            brd_q  <= bus.b_rd_en;
            bend_q <= bus.b_rd_en & bus.b_part_end;
        end
    end

    // Bias FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bwp_q  <= '0;
            brp_q  <= '0;
            bcnt_q <= '0;
        end else if (start) begin
            bwp_q  <= '0;
            brp_q  <= '0;
            bcnt_q <= '0;
        end else begin
            if (b_wr) bwp_q <= bwp_q + PTR_W'(1);
            if (pop)  brp_q <= brp_q + PTR_W'(1);
            bcnt_q <= bcnt_q + CNT_W'(b_wr) - CNT_W'(pop);
        end
    end

    // Bias FIFO storage
    always_ff @(posedge clk) begin
        if (b_wr) begin
            bmem_q[bwp_q] <= {bus.b_data, bend_q};
        end
    end

    // PE FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwp_q  <= '0;
            prp_q  <= '0;
            pcnt_q <= '0;
        end else if (start) begin
            pwp_q  <= '0;
            prp_q  <= '0;
            pcnt_q <= '0;
        end else begin
            if (p_wr) pwp_q <= pwp_q + PTR_W'(1);
            if (pop)  prp_q <= prp_q + PTR_W'(1);
            pcnt_q <= pcnt_q + CNT_W'(p_wr) - CNT_W'(pop);
        end
    end

    // PE FIFO storage
    always_ff @(posedge clk) begin
        if (p_wr) begin
            pmem_q[pwp_q] <= bus.pe_data;
        end
    end

    // Latch the requantisation settings on each start pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            relu_q  <= 1'b0;
        end else if (start) begin
            shift_q <= bus.shift;
            relu_q  <= bus.relu_en;
        end
    end

    // ---- stage p0: FIFO heads -> biased, rounded, saturated lanes ----
    always_comb begin
        res_d  = '0;
        psum_l = '0;
        bias_l = '0;
        sum_l  = '0;
        for (int l = 0; l < LANES; l++) begin
            psum_l = p_head[l*PSUM_W +: PSUM_W];
            bias_l = b_head[1 + l*BIAS_W +: BIAS_W];
            sum_l  = SUM_W'(psum_l) + SUM_W'(bias_l);
            res_d[l*OUT_W +: OUT_W] = sat_relu(round_shift(sum_l, shift_q), relu_q);
        end
    end

    // ---- stage p1: registered result, status and counters ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= pop;
            done_q  <= pop && pop_tag;
            if (pop) begin
                data_q <= res_d;
            end
            if (start) begin
                cnt_q <= '0;
            end else if (pop && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (start) begin
                err_q <= 1'b0;
            end else if (b_drop || p_drop) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.o_valid = valid_q;
    assign bus.o_data  = data_q;
    assign bus.o_done  = done_q;
    assign bus.o_cnt   = cnt_q;
    assign bus.o_err   = err_q;

endmodule

// File: tb/tb_bias_add_unit.sv
// Testbench for bias_add_unit.
// It uses a queue-based reference model with a scoreboard and combines directed and randomized stimulus.
module tb_bias_add_unit;

    localparam int LANES  = 4;
    localparam int PSUM_W = 32;
    localparam int BIAS_W = 16;
    localparam int OUT_W  = 8;
    localparam int DEPTH  = 4;

    localparam int ST_IDLE = 0;
    localparam int ST_RUN  = 1;
    localparam int ST_DONE = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    bias_add_unit_if #(.LANES(LANES), .PSUM_W(PSUM_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W)) bus ();

    bias_add_unit #(
        .LANES(LANES), .PSUM_W(PSUM_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W), .DEPTH(DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LANES*OUT_W-1:0] data;
        bit                     done;
        int                     cnt;
    } exp_t;

    exp_t                      exp_q[$];
    int                        vectors = 0;
    int                        errors  = 0;
    bit                        mon_en  = 1'b0;

    // Reference model state
    logic [LANES*BIAS_W-1:0]   mb_data[$];
    bit                        mb_tag[$];
    logic [LANES*PSUM_W-1:0]   mp[$];
    int                        m_state  = ST_IDLE;
    bit                        m_prev_rd  = 1'b0;
    bit                        m_prev_end = 1'b0;
    int                        m_shift  = 0;
    bit                        m_relu   = 1'b0;
    bit                        m_err    = 1'b0;
    int                        m_cnt    = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // One lane: add, round half up, shift, clamp, optional ReLU.
    function automatic logic [OUT_W-1:0] ref_lane(input longint ps, input longint bs,
                                                  input int sh, input bit relu);
        longint s;
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (OUT_W-1)) - 1;
        lo = -(longint'(1) <<< (OUT_W-1));
        s  = ps + bs;
        if (sh > 0) s = (s + (longint'(1) <<< (sh-1))) >>> sh;
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        if (relu && s < 0) s = 0;
        return s[OUT_W-1:0];
    endfunction

    function automatic logic [LANES*PSUM_W-1:0] pack_ps(input int a0, input int a1,
                                                        input int a2, input int a3);
        logic [LANES*PSUM_W-1:0] v;
        v = {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
        return v;
    endfunction

    function automatic logic [PSUM_W-1:0] rnd_psum();
        int v;
        if ($urandom_range(0, 3) == 0) return $urandom;
        v = int'($urandom_range(0, 8191)) - 4096;
        return PSUM_W'(v);
    endfunction

    function automatic logic [BIAS_W-1:0] rnd_bias();
        int v;
        if ($urandom_range(0, 3) == 0) return BIAS_W'($urandom);
        v = int'($urandom_range(0, 511)) - 256;
        return BIAS_W'(v);
    endfunction

    // Apply one clock. The model consumes the inputs now on the bus, and its
    // visible results are committed just after the edge.
    task automatic cycle();
        bit st, pop, tag, have_e, new_err;
        exp_t e;
        logic [LANES*BIAS_W-1:0] bv;
        logic [LANES*PSUM_W-1:0] pv;
        st = bus.calculate_enble;
        have_e = 1'b0; new_err = m_err; pop = 1'b0; tag = 1'b0;
        e.data = '0; e.done = 1'b0; e.cnt = 0;
        if (st) begin
            mb_data.delete(); mb_tag.delete(); mp.delete();
            m_state = ST_RUN;
            m_shift = int'(bus.shift);
            m_relu  = bus.relu_en;
            new_err = 1'b0;
            m_cnt   = 0;
        end else begin
            if (mb_data.size() > 0 && mp.size() > 0) begin
                pop = 1'b1;
                bv  = mb_data.pop_front();
                tag = mb_tag.pop_front();
                pv  = mp.pop_front();
                for (int l = 0; l < LANES; l++) begin
                    e.data[l*OUT_W +: OUT_W] = ref_lane(
                        longint'($signed(pv[l*PSUM_W +: PSUM_W])),
                        longint'($signed(bv[l*BIAS_W +: BIAS_W])), m_shift, m_relu);
                end
                if (m_cnt < 65535) m_cnt++;
                e.done = tag;
                e.cnt  = m_cnt;
                have_e = 1'b1;
            end
            if (m_prev_rd) begin
                if (m_state == ST_RUN && mb_data.size() < DEPTH) begin
                    mb_data.push_back(bus.b_data);
                    mb_tag.push_back(m_prev_end);
                end else begin
                    new_err = 1'b1;
                end
            end
            if (bus.pe_out_en) begin
                if (m_state == ST_RUN && mp.size() < DEPTH) mp.push_back(bus.pe_data);
                else new_err = 1'b1;
            end
            if (m_state == ST_DONE) m_state = ST_IDLE;
            else if (m_state == ST_RUN && pop && tag) m_state = ST_DONE;
        end
        m_prev_rd  = bus.b_rd_en;
        m_prev_end = bus.b_part_end;
        @(posedge clk);
        if (have_e) exp_q.push_back(e);
        m_err = new_err;
        #1;
    endtask

    task automatic idle(input int n);
        bus.b_rd_en = 1'b0; bus.b_part_end = 1'b0; bus.pe_out_en = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic kick(input int sh, input bit relu);
        bus.calculate_enble = 1'b1;
        bus.shift = 5'(sh);
        bus.relu_en = relu;
        cycle();
        bus.calculate_enble = 1'b0;
    endtask

    // Issue a bias read and a PE result together, then check the result 3 cycles later.
    task automatic single(input string name, input logic [LANES*PSUM_W-1:0] pv,
                          input logic [LANES*BIAS_W-1:0] bv, input logic [LANES*OUT_W-1:0] expv);
        bus.b_data = bv; bus.pe_data = pv;
        bus.b_rd_en = 1'b1; bus.pe_out_en = 1'b1;
        cycle();
        bus.b_rd_en = 1'b0; bus.pe_out_en = 1'b0;
        chk({name, "_lat1"}, bus.o_valid, 0);
        cycle();
        chk({name, "_lat2"}, bus.o_valid, 0);
        cycle();
        chk({name, "_valid"}, bus.o_valid, 1);
        chk({name, "_data"}, bus.o_data, expv);
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        #1;
        chk({name, "_o_valid"}, bus.o_valid, 0);
        chk({name, "_o_data"},  bus.o_data,  0);
        chk({name, "_o_done"},  bus.o_done,  0);
        chk({name, "_o_cnt"},   bus.o_cnt,   0);
        chk({name, "_o_err"},   bus.o_err,   0);
        mb_data.delete(); mb_tag.delete(); mp.delete(); exp_q.delete();
        m_state = ST_IDLE; m_prev_rd = 1'b0; m_prev_end = 1'b0;
        m_shift = 0; m_relu = 1'b0; m_err = 1'b0; m_cnt = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Scoreboard monitor: every o_valid consumes one expected entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en && !rst) begin
            if (bus.o_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL unexpected_valid: o_valid=1 with o_data=0x%0h, expected no output at %0t",
                             bus.o_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("o_data", bus.o_data, e.data);
                    chk("o_done", bus.o_done, e.done);
                    chk("o_cnt",  bus.o_cnt,  e.cnt);
                end
            end else if (bus.o_done) begin
                vectors++; errors++;
                $display("FAIL stray_done: o_done=1 while o_valid=0, expected 0 at %0t", $time);
            end
            chk("o_err", bus.o_err, m_err);
        end
    end

    initial begin
        bus.calculate_enble = 1'b0; bus.shift = '0; bus.relu_en = 1'b0;
        bus.b_rd_en = 1'b0; bus.b_part_end = 1'b0; bus.b_data = '0;
        bus.pe_out_en = 1'b0; bus.pe_data = '0;
        #2;
        do_reset("reset");
        mon_en = 1'b1;
        idle(2);

        // PE write while IDLE flags an error; start clears it
        bus.pe_out_en = 1'b1; bus.pe_data = pack_ps(1, 2, 3, 4);
        cycle();
        bus.pe_out_en = 1'b0;
        chk("idle_write_err", bus.o_err, 1);
        idle(2);
        kick(0, 1'b0);
        chk("start_clears_err", bus.o_err, 0);

        // Basic bias add, shift 0: 5 + 10 = 15 in every lane, three cycles of latency
        single("basic", pack_ps(5, 5, 5, 5), {4{16'd10}}, {4{8'd15}});
        chk("basic_cnt", bus.o_cnt, 1);
        idle(3);

        // Three bias reads with part_end on the last, PE results every 3 cycles
        kick(0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            bus.b_rd_en    = (k < 3);
            bus.b_part_end = (k == 2);
            bus.pe_out_en  = (k % 3 == 0);
            for (int l = 0; l < LANES; l++) begin
                bus.b_data[l*BIAS_W +: BIAS_W]  = rnd_bias();
                bus.pe_data[l*PSUM_W +: PSUM_W] = rnd_psum();
            end
            cycle();
        end
        idle(4);
        chk("layer_cnt", bus.o_cnt, 3);
        bus.pe_out_en = 1'b1;
        cycle();
        bus.pe_out_en = 1'b0;
        chk("back_to_idle_err", bus.o_err, 1);
        idle(2);

        // Saturation, rounding and ReLU with shift 2
        kick(2, 1'b0);
        single("sat", pack_ps(1000, -1000, 6, 5), '0, 32'h0102807F);
        idle(2);
        kick(2, 1'b1);
        single("relu", pack_ps(1000, -1000, 6, 5), '0, 32'h0102007F);
        idle(2);

        // Overflow: five PE results with no bias reads; the fifth is dropped
        kick(0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            bus.pe_out_en = 1'b1;
            bus.pe_data   = pack_ps(k, k, k, k);
            cycle();
            if (k == 3) chk("fifo_fill_no_err", bus.o_err, 0);
        end
        bus.pe_out_en = 1'b0;
        chk("overflow_err", bus.o_err, 1);
        idle(4);

        // Randomized runs with varying strobe densities
        for (int run = 0; run < 6; run++) begin
            idle(2);
            kick(int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
            for (int c = 0; c < 150; c++) begin
                bus.b_rd_en    = ($urandom_range(0, 99) < 25 + run * 8);
                bus.b_part_end = ($urandom_range(0, 59) == 0);
                bus.pe_out_en  = ($urandom_range(0, 99) < 65 - run * 6);
                for (int l = 0; l < LANES; l++) begin
                    bus.b_data[l*BIAS_W +: BIAS_W]  = rnd_bias();
                    bus.pe_data[l*PSUM_W +: PSUM_W] = rnd_psum();
                end
                cycle();
            end
            idle(6);
        end

        // Reset with two entries queued: outputs clear and nothing is emitted afterwards
        kick(0, 1'b0);
        bus.pe_out_en = 1'b1;
        cycle();
        cycle();
        bus.pe_out_en = 1'b0;
        do_reset("midrun_reset");
        bus.b_rd_en = 1'b1; bus.b_data = {4{16'd1}};
        cycle();
        cycle();
        bus.b_rd_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("post_reset_no_valid", bus.o_valid, 0);
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
